// File: rtl/decode_sequencer.sv
// Top-level decode sequencer: walks UART reception, M2 and M1 decode stages,
// and arbitrates the single SRAM port between UART, M2, M1 and VGA.
module decode_sequencer #(
    parameter logic [25:0] UART_TIMEOUT = 26'd49999999,
    parameter logic [25:0] STAGE_LIMIT  = 26'd60000000
) (
    input  logic        CLOCK_50_I,
    input  logic        reset,
    input  logic        uart_rx_i,
    input  logic        uart_we_n,
    input  logic [17:0] uart_addr,
    input  logic [15:0] uart_wdata,
    input  logic        m2_done,
    input  logic        m1_done,
    input  logic        m2_we_n,
    input  logic [17:0] m2_addr,
    input  logic [15:0] m2_wdata,
    input  logic        m1_we_n,
    input  logic [17:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic [17:0] vga_addr,
    output logic        uart_init,
    output logic        uart_enable,
    output logic        m2_start,
    output logic        m1_start,
    output logic        vga_enable,
    output logic        sram_we_n,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_wdata,
    output logic [3:0]  owner,
    output logic        busy,
    output logic        stage_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UART_RX = 2'd1,
        M2      = 2'd2,
        M1      = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [25:0] timer_r, timer_s;
    logic        uart_init_r, uart_init_s;
    logic        uart_enable_r, uart_enable_s;
    logic        m2_start_r, m2_start_s;
    logic        m1_start_r, m1_start_s;
    logic        vga_enable_r, vga_enable_s;
    logic        stage_error_r, stage_error_s;

    // Owner bits are ordered {M1, M2, UART, VGA}; VGA owns the port whenever idle.
    function automatic logic [3:0] owner_of(input state_t st);
        logic [3:0] result;
        case (st)
            IDLE:    result = 4'b0001;
            UART_RX: result = 4'b0010;
            M2:      result = 4'b0100;
            M1:      result = 4'b1000;
            default: result = 4'b0001;
        endcase
        return result;
    endfunction

    // Next-state, timer and registered control-output computation.
    always_comb begin
        state_s       = state_r;
        timer_s       = timer_r;
        uart_init_s   = 1'b0;
        uart_enable_s = 1'b0;
        m2_start_s    = m2_start_r;
        m1_start_s    = m1_start_r;
        vga_enable_s  = vga_enable_r;
        stage_error_s = stage_error_r;
        case (state_r)
            IDLE: begin
                if (uart_rx_i == 1'b0) begin
                    state_s       = UART_RX;
                    uart_init_s   = 1'b1;
                    timer_s       = 26'd0;
                    vga_enable_s  = 1'b0;
                    stage_error_s = 1'b0;
                end else begin
                    vga_enable_s  = 1'b1;
                    m2_start_s    = 1'b0;
                    m1_start_s    = 1'b0;
                end
            end
            UART_RX: begin
                // The enable pulse trails the init pulse by exactly one cycle.
                uart_enable_s = uart_init_r;
                if (timer_r == UART_TIMEOUT) begin
                    state_s    = M2;
                    timer_s    = 26'd0;
                    m2_start_s = 1'b1;
                end else if (uart_we_n == 1'b0) begin
                    timer_s = 26'd0;
                end else begin
                    timer_s = timer_r + 26'd1;
                end
            end
            M2: begin
                // Completion is tested before the abort limit so done wins a tie.
                if (m2_done == 1'b1) begin
                    state_s    = M1;
                    timer_s    = 26'd0;
                    m2_start_s = 1'b0;
                    m1_start_s = 1'b1;
                end else if (timer_r == STAGE_LIMIT) begin
                    state_s       = IDLE;
                    timer_s       = 26'd0;
                    m2_start_s    = 1'b0;
                    m1_start_s    = 1'b0;
                    vga_enable_s  = 1'b1;
                    stage_error_s = 1'b1;
                end else begin
                    timer_s = timer_r + 26'd1;
                end
            end
            M1: begin
                if (m1_done == 1'b1) begin
                    state_s      = IDLE;
                    timer_s      = 26'd0;
                    m1_start_s   = 1'b0;
                    vga_enable_s = 1'b1;
                end else if (timer_r == STAGE_LIMIT) begin
                    state_s       = IDLE;
                    timer_s       = 26'd0;
                    m2_start_s    = 1'b0;
                    m1_start_s    = 1'b0;
                    vga_enable_s  = 1'b1;
                    stage_error_s = 1'b1;
                end else begin
                    timer_s = timer_r + 26'd1;
                end
            end
            default: begin
                state_s       = IDLE;
                timer_s       = 26'd0;
                m2_start_s    = 1'b0;
                m1_start_s    = 1'b0;
                vga_enable_s  = 1'b1;
            end
        endcase
    end

    // State, timer and control-output registers with synchronous reset.
    always_ff @(posedge CLOCK_50_I) begin
        if (reset) begin
            state_r       <= IDLE;
            timer_r       <= 26'd0;
            uart_init_r   <= 1'b0;
            uart_enable_r <= 1'b0;
            m2_start_r    <= 1'b0;
            m1_start_r    <= 1'b0;
            vga_enable_r  <= 1'b1;
            stage_error_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            timer_r       <= timer_s;
            uart_init_r   <= uart_init_s;
            uart_enable_r <= uart_enable_s;
            m2_start_r    <= m2_start_s;
            m1_start_r    <= m1_start_s;
            vga_enable_r  <= vga_enable_s;
            stage_error_r <= stage_error_s;
        end
    end

    // SRAM port mux keyed on the registered state; VGA never gets a write strobe.
    always_comb begin
        sram_we_n  = 1'b1;
        sram_addr  = vga_addr;
        sram_wdata = 16'd0;
        case (state_r)
            IDLE: begin
                sram_we_n  = 1'b1;
                sram_addr  = vga_addr;
                sram_wdata = 16'd0;
            end
            UART_RX: begin
                sram_we_n  = uart_we_n;
                sram_addr  = uart_addr;
                sram_wdata = uart_wdata;
            end
            M2: begin
                sram_we_n  = m2_we_n;
                sram_addr  = m2_addr;
                sram_wdata = m2_wdata;
            end
            M1: begin
                sram_we_n  = m1_we_n;
                sram_addr  = m1_addr;
                sram_wdata = m1_wdata;
            end
            default: begin
                sram_we_n  = 1'b1;
                sram_addr  = vga_addr;
                sram_wdata = 16'd0;
            end
        endcase
    end

    assign owner       = owner_of(state_r);
    assign busy        = (state_r != IDLE);
    assign uart_init   = uart_init_r;
    assign uart_enable = uart_enable_r;
    assign m2_start    = m2_start_r;
    assign m1_start    = m1_start_r;
    assign vga_enable  = vga_enable_r;
    assign stage_error = stage_error_r;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed self-checking bench for decode_sequencer with UART_TIMEOUT=20 and
// STAGE_LIMIT=50; expected values below are hand-derived cycle counts.
module tb_decode_sequencer;

    logic        clk;
    logic        reset;
    logic        uart_rx_i;
    logic        uart_we_n;
    logic [17:0] uart_addr;
    logic [15:0] uart_wdata;
    logic        m2_done;
    logic        m1_done;
    logic        m2_we_n;
    logic [17:0] m2_addr;
    logic [15:0] m2_wdata;
    logic        m1_we_n;
    logic [17:0] m1_addr;
    logic [15:0] m1_wdata;
    logic [17:0] vga_addr;
    logic        uart_init;
    logic        uart_enable;
    logic        m2_start;
    logic        m1_start;
    logic        vga_enable;
    logic        sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [3:0]  owner;
    logic        busy;
    logic        stage_error;

    int checks = 0;
    int errors = 0;
    int n;

    decode_sequencer #(
        .UART_TIMEOUT(26'd20),
        .STAGE_LIMIT (26'd50)
    ) dut (
        .CLOCK_50_I (clk),
        .reset      (reset),
        .uart_rx_i  (uart_rx_i),
        .uart_we_n  (uart_we_n),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .m2_done    (m2_done),
        .m1_done    (m1_done),
        .m2_we_n    (m2_we_n),
        .m2_addr    (m2_addr),
        .m2_wdata   (m2_wdata),
        .m1_we_n    (m1_we_n),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .vga_addr   (vga_addr),
        .uart_init  (uart_init),
        .uart_enable(uart_enable),
        .m2_start   (m2_start),
        .m1_start   (m1_start),
        .vga_enable (vga_enable),
        .sram_we_n  (sram_we_n),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .owner      (owner),
        .busy       (busy),
        .stage_error(stage_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_owner(input logic [3:0] want, input int limit);
        n = 0;
        while (owner !== want && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        uart_rx_i  = 1'b1;
        uart_we_n  = 1'b1;
        uart_addr  = 18'h2AAAA;
        uart_wdata = 16'h1111;
        m2_done    = 1'b0;
        m1_done    = 1'b0;
        m2_we_n    = 1'b0;
        m2_addr    = 18'h12345;
        m2_wdata   = 16'h2222;
        m1_we_n    = 1'b0;
        m1_addr    = 18'h23456;
        m1_wdata   = 16'h3333;
        vga_addr   = 18'h00ABC;

        // Reset state
        tick();
        check("rst_owner", owner, 4'b0001);
        check("rst_busy", busy, 1'b0);
        check("rst_vga_enable", vga_enable, 1'b1);
        check("rst_uart_init", uart_init, 1'b0);
        check("rst_uart_enable", uart_enable, 1'b0);
        check("rst_starts", {m2_start, m1_start}, 2'b00);
        check("rst_stage_error", stage_error, 1'b0);
        check("rst_sram_addr", sram_addr, 18'h00ABC);
        check("rst_sram_we_n", sram_we_n, 1'b1);
        check("rst_sram_wdata", sram_wdata, 16'h0000);

        // Idle with stray done pulses: nothing happens
        reset   = 1'b0;
        m2_done = 1'b1;
        m1_done = 1'b1;
        tick();
        m2_done = 1'b0;
        m1_done = 1'b0;
        check("idle_ignores_done", owner, 4'b0001);

        // Start bit: init pulse, then enable pulse
        uart_rx_i = 1'b0;
        tick();
        uart_rx_i = 1'b1;
        check("rx_uart_init", uart_init, 1'b1);
        check("rx_uart_enable0", uart_enable, 1'b0);
        check("rx_owner", owner, 4'b0010);
        check("rx_vga_enable", vga_enable, 1'b0);
        check("rx_busy", busy, 1'b1);
        check("rx_sram_addr", sram_addr, 18'h2AAAA);
        tick();
        check("rx_uart_init_drop", uart_init, 1'b0);
        check("rx_uart_enable1", uart_enable, 1'b1);
        tick();
        check("rx_uart_enable_drop", uart_enable, 1'b0);

        // Write pulses every 10 cycles keep the timer from expiring
        for (int p = 0; p < 3; p++) begin
            uart_we_n = 1'b0;
            #1;
            check("rx_sram_we_pass", sram_we_n, 1'b0);
            tick();
            uart_we_n = 1'b1;
            repeat (9) tick();
            check("rx_hold_owner", owner, 4'b0010);
        end
        uart_we_n = 1'b0;
        tick();
        uart_we_n = 1'b1;
        wait_owner(4'b0100, 40);
        check("m2_entry_latency", n, 21);
        check("m2_start", m2_start, 1'b1);
        check("m2_sram_addr", sram_addr, 18'h12345);
        check("m2_sram_wdata", sram_wdata, 16'h2222);

        // M2 done at cycle 5 (m1_done held high is ignored in M2)
        m1_done = 1'b1;
        repeat (4) tick();
        m1_done = 1'b0;
        check("m2_ignores_m1_done", owner, 4'b0100);
        m2_done = 1'b1;
        tick();
        m2_done = 1'b0;
        check("m1_owner", owner, 4'b1000);
        check("m1_starts", {m2_start, m1_start}, 2'b01);
        check("m1_sram_addr", sram_addr, 18'h23456);
        repeat (6) tick();
        m1_done = 1'b1;
        tick();
        m1_done = 1'b0;
        check("done_owner", owner, 4'b0001);
        check("done_vga_enable", vga_enable, 1'b1);
        check("done_stage_error", stage_error, 1'b0);
        check("done_m1_start", m1_start, 1'b0);

        // M2 abort after 51 cycles
        uart_rx_i = 1'b0;
        tick();
        uart_rx_i = 1'b1;
        wait_owner(4'b0100, 40);
        check("abort_m2_entry", n, 21);
        wait_owner(4'b0001, 80);
        check("abort_m2_cycles", n, 51);
        check("abort_stage_error", stage_error, 1'b1);
        check("abort_starts", {m2_start, m1_start}, 2'b00);
        check("abort_vga_enable", vga_enable, 1'b1);
        tick();
        check("abort_sticky", stage_error, 1'b1);
        uart_rx_i = 1'b0;
        tick();
        uart_rx_i = 1'b1;
        check("abort_clear", stage_error, 1'b0);

        // m1_done in the same cycle the timer reaches the limit
        wait_owner(4'b0100, 40);
        check("tie_m2_entry", n, 21);
        m2_done = 1'b1;
        tick();
        m2_done = 1'b0;
        repeat (50) tick();
        check("tie_still_m1", owner, 4'b1000);
        m1_done = 1'b1;
        tick();
        m1_done = 1'b0;
        check("tie_owner", owner, 4'b0001);
        check("tie_stage_error", stage_error, 1'b0);

        // Reset in the middle of M1
        uart_rx_i = 1'b0;
        tick();
        uart_rx_i = 1'b1;
        wait_owner(4'b0100, 40);
        m2_done = 1'b1;
        tick();
        m2_done = 1'b0;
        repeat (3) tick();
        check("mid_m1_start", m1_start, 1'b1);
        reset     = 1'b1;
        uart_rx_i = 1'b0;
        tick();
        check("rst_m1_owner", owner, 4'b0001);
        check("rst_m1_start", m1_start, 1'b0);
        check("rst_m1_sram_we_n", sram_we_n, 1'b1);
        check("rst_m1_sram_addr", sram_addr, 18'h00ABC);
        tick();
        check("rst_holds_idle", owner, 4'b0001);
        reset     = 1'b0;
        uart_rx_i = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter UART_TIMEOUT, default 26'd49999999, is the idle-cycle count on UART writes that ends reception.
REQ-002 Parameter STAGE_LIMIT, default 26'd60000000, is the maximum cycles a decode stage may run before abort.
REQ-003 CLOCK_50_I  in  1  single 50 MHz clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 uart_rx_i  in  1  raw UART RX line; a low level is a start bit.
REQ-006 uart_we_n / uart_addr / uart_wdata  in  1/18/16  UART-to-SRAM write request.
REQ-007 m2_done / m1_done  in  1  stage completion from the M2 and M1 units; level or pulse.
REQ-008 m2_we_n / m2_addr / m2_wdata  in  1/18/16  M2 SRAM request.
REQ-009 m1_we_n / m1_addr / m1_wdata  in  1/18/16  M1 SRAM request.
REQ-010 vga_addr  in  18  VGA read address.
REQ-011 uart_init / uart_enable  out  1  UART receiver synchronisation pulses.
REQ-012 m2_start / m1_start  out  1  stage run levels.
REQ-013 vga_enable  out  1  VGA fetch enable.
REQ-014 sram_we_n / sram_addr / sram_wdata  out  1/18/16  arbitrated SRAM controller request.
REQ-015 owner  out  4  one-hot SRAM owner {M1,M2,UART,VGA}.
REQ-016 busy / stage_error  out  1  not-idle flag; sticky stage-abort flag.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, UART_RX, M2 and M1, held in registers together with a 26-bit timer.
REQ-018 In IDLE, vga_enable SHALL be 1; uart_rx_i==0 SHALL register UART_RX, uart_init=1, timer=0, vga_enable=0 and stage_error=0 on the next edge.
REQ-019 In UART_RX, uart_init SHALL be 1 for exactly one cycle, and uart_enable SHALL be a single one-cycle pulse in the cycle after uart_init.
REQ-020 In UART_RX, the timer SHALL increment each cycle and clear in any cycle with uart_we_n==0.
REQ-021 When the UART_RX timer equals UART_TIMEOUT, the FSM SHALL move to M2 with timer=0.
REQ-022 In M2, m2_start SHALL be 1 from the first M2 cycle.
REQ-023 On m2_done==1 in M2, the next state SHALL be M1, with m2_start=0, m1_start=1 and timer=0.
REQ-024 On m1_done==1 in M1, the next state SHALL be IDLE, with m1_start=0 and vga_enable=1.
REQ-025 In M2/M1, if the timer equals STAGE_LIMIT without done, the FSM SHALL go to IDLE with both starts 0 and stage_error=1.
REQ-026 If done and the STAGE_LIMIT condition occur in the same cycle, done SHALL win.
REQ-027 Done inputs outside their matching state SHALL be ignored, and uart_rx_i SHALL be ignored outside IDLE.
REQ-028 The SRAM mux SHALL be combinational on the registered state: UART_RX selects uart_*, M2 selects m2_*, M1 selects m1_*.
REQ-029 In IDLE, the SRAM mux SHALL select vga_addr with sram_we_n=1 and sram_wdata=0.
REQ-030 Exactly one owner bit SHALL be set in every cycle; busy SHALL equal (state != IDLE).
REQ-031 sram_we_n SHALL never be 0 while owner is VGA.

Reset
REQ-032 On reset=1 at an edge, the block SHALL register state=IDLE, timer=0, uart_init=0, uart_enable=0, m1_start=0, m2_start=0, vga_enable=1 and stage_error=0.
REQ-033 After reset, the SRAM outputs SHALL be vga_addr, sram_we_n=1 and sram_wdata=0, with owner=4'b0001.
REQ-034 Reset SHALL take priority over every other input, including an in-progress stage, in which case both starts drop on the next edge.

Verification (UART_TIMEOUT=20, STAGE_LIMIT=50)
REQ-035 Bench SHALL cover: uart_rx_i low in IDLE -> uart_init high 1 cycle, uart_enable high the following cycle, owner=0010, vga_enable=0.
REQ-036 Bench SHALL cover: uart_we_n pulses every 10 cycles then stop -> M2 is entered exactly 21 cycles after the last pulse, with m2_start=1 and owner=0100.
REQ-037 Bench SHALL cover: m2_done at M2 cycle 5, then m1_done at M1 cycle 7 -> M1 is entered with owner=1000, then IDLE with vga_enable=1 and stage_error=0.
REQ-038 Bench SHALL cover: no m2_done -> IDLE after 51 M2 cycles with stage_error=1, and stage_error clears on the next uart_rx_i low.
REQ-039 Bench SHALL cover: m1_done coinciding with timer==50 -> normal IDLE with stage_error=0.
REQ-040 Bench SHALL cover: reset asserted mid-M1 -> next edge state IDLE, m1_start=0, sram_we_n=1 and sram_addr=vga_addr.
